// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared encodings for the screen sequencer
// Purpose: screen-select codes, FSM state and pending-request encodings, and
//          the state-to-screen mapping used by the registered screen_sel.
// Ports:   none (package).
package screen_pkg;

    localparam logic [1:0] SCR_TITLE = 2'd0;
    localparam logic [1:0] SCR_PLAY  = 2'd1;
    localparam logic [1:0] SCR_WIN   = 2'd2;
    localparam logic [1:0] SCR_LOSE  = 2'd3;

    typedef enum logic [1:0] {
        ST_TITLE  = 2'd0,
        ST_PLAY   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_PLAY   = 2'd1,
        REQ_RESULT = 2'd2
    } req_t;

    // RESULT splits into win/lose screens on the latched winner.
    function automatic logic [1:0] screen_code(input state_t st, input logic win);
        logic [1:0] code;
        case (st)
            ST_PLAY:   code = SCR_PLAY;
            ST_RESULT: code = win ? SCR_WIN : SCR_LOSE;
            default:   code = SCR_TITLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/screen_sequencer_rise_detect.sv
// rtl/screen_sequencer_rise_detect.sv - single-flop edge detector
// Purpose: registers d and flags an edge against the registered copy.
//          FALLING = 0 flags d & ~d_q, FALLING = 1 flags d_q & ~d.
// Ports:   clk, rst_n (async active-low, loads IDLE), d (level in),
//          rise (combinational one-cycle edge flag).
module rise_detect #(
    parameter logic IDLE    = 1'b0,
    parameter bit   FALLING = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    import screen_pkg::*;

    logic d_q;
    logic d_d;

    always_comb begin
        d_d  = d;
        rise = FALLING ? (d_q & ~d) : (d & ~d_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= IDLE;
        end else begin
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - frame-synchronous title/play/result screen controller
// Purpose: tracks game phase and commits screen changes only on vsync falling
//          edges; drives registered screen select and result-banner blink.
// Ports:   clk, rst (async active-low), vsync (active-low pulse),
//          start_btn (level), game_over (pulse), winner (sampled with game_over),
//          screen_sel[1:0], blink_on, frame_tick (registered vsync-fall pulse).
module screen_sequencer #(
    parameter int BLINK_FRAMES  = 30,
    parameter int RESULT_FRAMES = 600,
    parameter int FRAME_W       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic       winner,
    output logic [1:0] screen_sel,
    output logic       blink_on,
    output logic       frame_tick
);
    import screen_pkg::*;

    localparam logic [FRAME_W-1:0] RESULT_LAST = FRAME_W'(RESULT_FRAMES - 1);
    localparam logic [FRAME_W-1:0] BLINK_LAST  = FRAME_W'(BLINK_FRAMES - 1);

    logic tick;
    logic start_rise;

    // vsync idles high, so its detector resets to 1 and looks for the fall.
    rise_detect #(.IDLE(1'b1), .FALLING(1'b1)) u_vsync_fall (
        .clk   (clk),
        .rst_n (rst),
        .d     (vsync),
        .rise  (tick)
    );

    rise_detect #(.IDLE(1'b0), .FALLING(1'b0)) u_start_rise (
        .clk   (clk),
        .rst_n (rst),
        .d     (start_btn),
        .rise  (start_rise)
    );

    state_t             state_q, state_d;
    req_t               pending_q, pending_d;
    req_t               req_now, req_eff;
    logic               win_q, win_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [1:0]         screen_sel_q, screen_sel_d;
    logic               blink_on_q, blink_on_d;
    logic               frame_tick_q, frame_tick_d;

    always_comb begin
        req_now     = REQ_NONE;
        win_d       = win_q;
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        // Each state accepts only one kind of request, so game_over beating a
        // simultaneous start in PLAY falls out of the case split.
        case (state_q)
            ST_TITLE:  if (start_rise) req_now = REQ_PLAY;
            ST_PLAY: begin
                if (game_over) begin
                    req_now = REQ_RESULT;
                    win_d   = winner;
                end
            end
            ST_RESULT: if (start_rise) req_now = REQ_PLAY;
            default:   req_now = REQ_NONE;
        endcase

        req_eff   = (req_now != REQ_NONE) ? req_now : pending_q;
        pending_d = req_eff;

        if (tick) begin
            pending_d = REQ_NONE;
            if (req_eff == REQ_PLAY) begin
                state_d = ST_PLAY;
            end else if (req_eff == REQ_RESULT) begin
                state_d     = ST_RESULT;
                frame_cnt_d = '0;
                blink_cnt_d = '0;
                blink_d     = 1'b1;
            end else if (state_q == ST_RESULT) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
                if (frame_cnt_q == RESULT_LAST) begin
                    state_d = ST_TITLE;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end

        // Counters park at zero and the banner phase at "on" outside RESULT.
        if (state_d != ST_RESULT) begin
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end

        // Output stage lags the commit by one clk so it settles in blanking.
        screen_sel_d = screen_code(state_q, win_q);
        blink_on_d   = (state_q == ST_RESULT) ? blink_q : 1'b1;
        frame_tick_d = tick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_TITLE;
            pending_q    <= REQ_NONE;
            win_q        <= 1'b0;
            frame_cnt_q  <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b1;
            screen_sel_q <= SCR_TITLE;
            blink_on_q   <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            win_q        <= win_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            screen_sel_q <= screen_sel_d;
            blink_on_q   <= blink_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign screen_sel = screen_sel_q;
    assign blink_on   = blink_on_q;
    assign frame_tick = frame_tick_q;

endmodule
